pixel_row_serializer: RTL and testbench

// - Parametrised successor to the row-to-FIFO pixel queue.
// - Accepts a full row of PIXELS pixels on a valid/ready handshake and emits one pixel per accepted cycle.
// - Output is a valid/ready stream with backpressure, feeding the pixel FIFO ahead of the display path.
// - Adds a second row buffer for gap-free back-to-back rows, per-row horizontal flip, and synchronous flush.

---
 rtl/pixel_pkg.sv | 16 +
 rtl/pixel_row_buf.sv | 34 +++
 rtl/pixel_row_serializer.sv | 141 ++++++++++++++
 tb/tb_pixel_row_serializer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared types and defaults for the pixel row serializer
// Purpose: default pixel width, pixel type and serializer state encoding.
// Ports:   none (package).
package pixel_pkg;

   localparam int PIXEL_W_DEFAULT = 6;

   typedef logic [PIXEL_W_DEFAULT-1:0] pixel_t;

   typedef enum logic [1:0] {
      S_EMPTY    = 2'd0,
      S_RUN      = 2'd1,
      S_RUN_PEND = 2'd2
   } ser_state_t;

endpackage

// File: rtl/pixel_row_buf.sv
// rtl/pixel_row_buf.sv - loadable row + flip register with synchronous clear
// Purpose: holds one row of pixels and its flip flag.
// Ports:   clk_in, rst_n_in (async active-low), clear_in (sync, beats load),
//          load_in, row_in/flip_in (load data), row_out/flip_out (stored row).
module pixel_row_buf
   import pixel_pkg::*;
#(
   parameter int PIXELS  = 8,
   parameter int PIXEL_W = PIXEL_W_DEFAULT
) (
   input  logic                            clk_in,
   input  logic                            rst_n_in,
   input  logic                            clear_in,
   input  logic                            load_in,
   input  logic [PIXELS-1:0][PIXEL_W-1:0]  row_in,
   input  logic                            flip_in,
   output logic [PIXELS-1:0][PIXEL_W-1:0]  row_out,
   output logic                            flip_out
);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         row_out  <= '0;
         flip_out <= 1'b0;
      end else if (clear_in) begin
         row_out  <= '0;
         flip_out <= 1'b0;
      end else if (load_in) begin
         row_out  <= row_in;
         flip_out <= flip_in;
      end
   end

endmodule

// File: rtl/pixel_row_serializer.sv
// rtl/pixel_row_serializer.sv - double-buffered row to pixel stream serializer
// Purpose: accepts whole rows on a valid/ready handshake and emits one pixel
//          per accepted cycle, with per-row flip, a pending row buffer for
//          gap-free back-to-back rows, and synchronous flush.
// Ports:   clk_in, rst_n_in (async active-low), flush_in (sync clear);
//          row_in/row_flip_in/row_valid_in/row_ready_out (row side);
//          pix_out/pix_valid_out/pix_ready_in/pix_last_out/pix_idx_out
//          (pixel side); done_out (pulse one cycle after each row's last pixel).
module pixel_row_serializer
   import pixel_pkg::*;
#(
   parameter  int PIXELS  = 8,
   parameter  int PIXEL_W = PIXEL_W_DEFAULT,
   localparam int IDX_W   = $clog2(PIXELS)
) (
   input  logic                            clk_in,
   input  logic                            rst_n_in,
   input  logic                            flush_in,
   input  logic [PIXELS-1:0][PIXEL_W-1:0]  row_in,
   input  logic                            row_flip_in,
   input  logic                            row_valid_in,
   output logic                            row_ready_out,
   output logic [PIXEL_W-1:0]              pix_out,
   output logic                            pix_valid_out,
   input  logic                            pix_ready_in,
   output logic                            pix_last_out,
   output logic [IDX_W-1:0]                pix_idx_out,
   output logic                            done_out
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS - 1);

   ser_state_t                       state;
   logic [IDX_W-1:0]                 idx;
   logic                             done_q;

   logic [PIXELS-1:0][PIXEL_W-1:0]   act_row;
   logic                             act_flip;
   logic [PIXELS-1:0][PIXEL_W-1:0]   pend_row;
   logic                             pend_flip;

   logic                             acc;
   logic                             adv;
   logic                             row_end;
   logic                             act_load;
   logic                             act_from_pend;
   logic                             pend_load;
   logic [PIXELS-1:0][PIXEL_W-1:0]   act_load_row;
   logic                             act_load_flip;
   logic [IDX_W-1:0]                 sel;

   assign row_ready_out = (state != S_RUN_PEND);
   assign pix_valid_out = (state != S_EMPTY);
   assign pix_last_out  = pix_valid_out && (idx == LAST_IDX);
   assign pix_idx_out   = idx;
   assign done_out      = done_q;

   assign acc     = row_valid_in && row_ready_out;
   assign adv     = pix_valid_out && pix_ready_in;
   assign row_end = adv && (idx == LAST_IDX);

   // Active buffer is refilled either straight from the input (empty, or
   // zero-gap reload at row end) or from the pending buffer.
   assign act_from_pend = (state == S_RUN_PEND) && row_end;
   assign act_load      = act_from_pend
                        || ((state == S_EMPTY) && acc)
                        || ((state == S_RUN) && row_end && acc);
   assign act_load_row  = act_from_pend ? pend_row  : row_in;
   assign act_load_flip = act_from_pend ? pend_flip : row_flip_in;
   assign pend_load     = (state == S_RUN) && acc && !row_end;

   // Unflipped rows emit the highest element first.
   assign sel     = act_flip ? idx : (LAST_IDX - idx);
   assign pix_out = pix_valid_out ? act_row[sel] : '0;

   pixel_row_buf #(.PIXELS(PIXELS), .PIXEL_W(PIXEL_W)) u_act_buf (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .clear_in (flush_in),
      .load_in  (act_load),
      .row_in   (act_load_row),
      .flip_in  (act_load_flip),
      .row_out  (act_row),
      .flip_out (act_flip)
   );

   pixel_row_buf #(.PIXELS(PIXELS), .PIXEL_W(PIXEL_W)) u_pend_buf (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .clear_in (flush_in),
      .load_in  (pend_load),
      .row_in   (row_in),
      .flip_in  (row_flip_in),
      .row_out  (pend_row),
      .flip_out (pend_flip)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state  <= S_EMPTY;
         idx    <= '0;
         done_q <= 1'b0;
      end else if (flush_in) begin
         state  <= S_EMPTY;
         idx    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= row_end;
         case (state)
            S_EMPTY: begin
               if (acc) begin
                  state <= S_RUN;
                  idx   <= '0;
               end
            end
            S_RUN: begin
               if (row_end) begin
                  idx   <= '0;
                  state <= acc ? S_RUN : S_EMPTY;
               end else begin
                  if (adv) idx <= idx + 1'b1;
                  if (acc) state <= S_RUN_PEND;
               end
            end
            S_RUN_PEND: begin
               if (row_end) begin
                  idx   <= '0;
                  state <= S_RUN;
               end else if (adv) begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state <= S_EMPTY;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_row_serializer.sv
// tb/tb_pixel_row_serializer.sv - self-checking bench for pixel_row_serializer
module tb_pixel_row_serializer;

   typedef logic [7:0][5:0] row_t;

   typedef struct {
      int rv;
      int flip;
      int pr;
      int exp_rr;
      int exp_v;
      int exp_pix;
      int exp_last;
      int exp_idx;
      int exp_done;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       flush;
   row_t       row;
   logic       flip;
   logic       row_valid;
   logic       row_ready;
   logic [5:0] pix;
   logic       pix_valid;
   logic       pix_ready;
   logic       pix_last;
   logic [2:0] pix_idx;
   logic       done;

   int vectors;
   int miscompares;

   // reference model: queue of accepted rows already in emission order
   row_t mq[$];
   int   pos;
   int   mdone;
   int   macc;

   vec_t tbl[20];

   pixel_row_serializer #(.PIXELS(8), .PIXEL_W(6)) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .flush_in      (flush),
      .row_in        (row),
      .row_flip_in   (flip),
      .row_valid_in  (row_valid),
      .row_ready_out (row_ready),
      .pix_out       (pix),
      .pix_valid_out (pix_valid),
      .pix_ready_in  (pix_ready),
      .pix_last_out  (pix_last),
      .pix_idx_out   (pix_idx),
      .done_out      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      pos   = 0;
      mdone = 0;
      macc  = 0;
   endtask

   task automatic model_step();
      int   adv;
      int   fin;
      row_t em;
      macc = 0;
      if (flush) begin
         model_reset();
      end else begin
         macc = (row_valid && mq.size() < 2) ? 1 : 0;
         adv  = (mq.size() > 0 && pix_ready) ? 1 : 0;
         fin  = 0;
         if (adv != 0) begin
            if (pos == 7) begin
               void'(mq.pop_front());
               pos = 0;
               fin = 1;
            end else begin
               pos++;
            end
         end
         if (macc != 0) begin
            for (int k = 0; k < 8; k++) em[k] = flip ? row[k] : row[7-k];
            mq.push_back(em);
         end
         mdone = fin;
      end
   endtask

   task automatic check_model();
      int v;
      v = (mq.size() > 0) ? 1 : 0;
      chk("row_ready", int'(row_ready), (mq.size() < 2) ? 1 : 0);
      chk("pix_valid", int'(pix_valid), v);
      chk("pix_out",   int'(pix),       (v != 0) ? int'(mq[0][pos]) : 0);
      chk("pix_last",  int'(pix_last),  (v != 0 && pos == 7) ? 1 : 0);
      chk("pix_idx",   int'(pix_idx),   pos);
      chk("done",      int'(done),      mdone);
   endtask

   task automatic half();
      @(negedge clk);
      check_model();
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_base_row();
      for (int k = 0; k < 8; k++) row[k] = 6'(k + 1);
   endtask

   initial begin
      int n;
      int vcnt;
      int dcnt;
      int rlow;
      int first_v;
      int last_v;
      int guard;

      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      flip        = 1'b0;
      row_valid   = 1'b0;
      pix_ready   = 1'b1;
      set_base_row();
      model_reset();

      // single row (flip=0) then flipped row, cycle by cycle
      tbl[0] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < 8; i++)
         tbl[1+i] = '{0, 0, 1, 1, 1, 8 - i, (i == 7) ? 1 : 0, i, 0};
      tbl[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
      for (int i = 0; i < 8; i++)
         tbl[10+i] = '{0, 0, 1, 1, 1, i + 1, (i == 7) ? 1 : 0, i, 0};
      tbl[18] = '{0, 0, 1, 1, 0, 0, 0, 0, 1};
      tbl[19] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         row_valid = tbl[i].rv[0];
         flip      = tbl[i].flip[0];
         pix_ready = tbl[i].pr[0];
         half();
         chk("tbl_rr",   int'(row_ready), tbl[i].exp_rr);
         chk("tbl_v",    int'(pix_valid), tbl[i].exp_v);
         chk("tbl_pix",  int'(pix),       tbl[i].exp_pix);
         chk("tbl_last", int'(pix_last),  tbl[i].exp_last);
         chk("tbl_idx",  int'(pix_idx),   tbl[i].exp_idx);
         chk("tbl_done", int'(done),      tbl[i].exp_done);
         edge_step();
      end

      // back-to-back rows held valid
      n = 0; vcnt = 0; dcnt = 0; rlow = 0; first_v = -1; last_v = -1;
      pix_ready = 1'b1;
      flip      = 1'b0;
      row_valid = 1'b1;
      for (int k = 0; k < 8; k++) row[k] = 6'(k + 1);
      for (int c = 0; c < 30; c++) begin
         half();
         if (pix_valid) begin
            vcnt++;
            if (first_v < 0) first_v = c;
            last_v = c;
         end
         if (done) dcnt++;
         if (!row_ready) rlow++;
         edge_step();
         if (macc != 0) begin
            n++;
            if (n == 3) row_valid = 1'b0;
            else for (int k = 0; k < 8; k++) row[k] = 6'(8 * n + k + 1);
         end
      end
      chk("b2b_valid_count", vcnt, 24);
      chk("b2b_contiguous", last_v - first_v + 1, 24);
      chk("b2b_done_count", dcnt, 3);
      chk("b2b_ready_low", rlow, 14);

      // backpressure at idx 3
      set_base_row();
      row_valid = 1'b1;
      half();
      edge_step();
      row_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         half();
         edge_step();
      end
      pix_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         half();
         chk("stall_pix", int'(pix), 5);
         chk("stall_idx", int'(pix_idx), 3);
         chk("stall_valid", int'(pix_valid), 1);
         edge_step();
      end
      pix_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         half();
         chk("resume_pix", int'(pix), 5 - i);
         edge_step();
      end
      half();
      chk("resume_done", int'(done), 1);
      edge_step();

      // flush at idx 5 with pending loaded
      row_valid = 1'b1;
      half();
      edge_step();
      half();
      edge_step();
      row_valid = 1'b0;
      guard = 0;
      while (pos != 5 && guard < 20) begin
         half();
         edge_step();
         guard++;
      end
      chk("flush_reach_idx5", int'(pix_idx), 5);
      chk("flush_pend_full", int'(row_ready), 0);
      flush     = 1'b1;
      row_valid = 1'b1;
      half();
      edge_step();
      flush     = 1'b0;
      row_valid = 1'b0;
      half();
      chk("flush_valid", int'(pix_valid), 0);
      chk("flush_rr", int'(row_ready), 1);
      chk("flush_done", int'(done), 0);
      edge_step();
      half();
      chk("flush_done2", int'(done), 0);
      chk("flush_dropped_row", int'(pix_valid), 0);
      row_valid = 1'b1;
      edge_step();
      row_valid = 1'b0;
      half();
      chk("post_flush_idx", int'(pix_idx), 0);
      chk("post_flush_pix", int'(pix), 8);
      edge_step();

      // asynchronous reset mid-row
      for (int i = 0; i < 2; i++) begin
         half();
         edge_step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(pix_valid), 0);
      chk("arst_pix", int'(pix), 0);
      chk("arst_last", int'(pix_last), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_rr", int'(row_ready), 1);
      chk("arst_idx", int'(pix_idx), 0);
      model_reset();
      #2;
      rst_n = 1'b1;
      row_valid = 1'b1;
      flip = 1'b1;
      edge_step();
      row_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         half();
         if (i < 8) chk("post_rst_pix", int'(pix), i + 1);
         edge_step();
      end

      // randomized traffic against the queue model
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 8; k++) row[k] = 6'($urandom_range(63));
         flip      = 1'($urandom_range(1));
         row_valid = 1'($urandom_range(1));
         pix_ready = ($urandom_range(3) != 0);
         flush     = ($urandom_range(39) == 0);
         half();
         edge_step();
      end
      flush = 1'b0;
      row_valid = 1'b0;
      pix_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         half();
         edge_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
